aes_core_arbiter: RTL and testbench

- Shares the single centralized AES block-cipher core among NREQ requesters: H-subkey generation, CTR keystream and J0 tag mask.
- Accepts level requests, grants one requester at a time round-robin, and acknowledges the grant with a one-cycle ack.
- Launches the core, then returns the encrypted block to the granted requester as a one-hot valid pulse.
- Sits between the GCM sub-blocks and the AES core instance.

---
 rtl/aes_core_arbiter.sv | 178 +++++++++++++++++
 tb/tb_aes_core_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_arbiter.sv
// ============================================================================
// Module   : aes_core_arbiter
// Purpose  : Round-robin sharing of one AES core among NREQ GCM requesters.
//            Optional macro AES_ARB_PRIO0_EN gives requester 0 strict priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_core_arbiter #(
    parameter int NREQ  = 3,
    parameter int BLK_W = 128,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*BLK_W-1:0] req_blk,
    output logic [NREQ-1:0]       ack,
    output logic [BLK_W-1:0]      rsp_data,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    input  logic                  flush,
    input  logic                  core_ready,
    output logic                  core_start,
    output logic [BLK_W-1:0]      core_block,
    input  logic                  core_done,
    input  logic [BLK_W-1:0]      core_result,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_gnt;
    logic [NREQ-1:0]    r_ack;
    logic               r_core_start;
    logic [BLK_W-1:0]   r_core_block;
    logic [NREQ-1:0]    r_rsp_valid;
    logic [BLK_W-1:0]   r_rsp_data;
    logic [IDW-1:0]     r_rsp_id;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [IDW-1:0]     w_rr_nxt;
    logic [IDW-1:0]     w_gnt_nxt;
    logic [NREQ-1:0]    w_ack_nxt;
    logic               w_start_nxt;
    logic [BLK_W-1:0]   w_block_nxt;
    logic [NREQ-1:0]    w_valid_nxt;
    logic [BLK_W-1:0]   w_data_nxt;
    logic [IDW-1:0]     w_id_nxt;

    logic               w_found;
    logic [IDW-1:0]     w_win;
    logic [NREQ-1:0]    w_win_oh;
    logic [NREQ-1:0]    w_gnt_oh;
    int                 w_idx;

    // Rotating search starting just above the last winner, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(w_idx);
            end
        end
`ifdef AES_ARB_PRIO0_EN
        if (req[0]) begin
            w_found = 1'b1;
            w_win   = '0;
        end
`endif
    end

    assign w_win_oh = NREQ'(1) << w_win;
    assign w_gnt_oh = NREQ'(1) << r_gnt;

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_gnt_nxt   = r_gnt;
        w_ack_nxt   = '0;
        w_start_nxt = 1'b0;
        w_block_nxt = r_core_block;
        w_valid_nxt = '0;
        w_data_nxt  = r_rsp_data;
        w_id_nxt    = r_rsp_id;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_ISSUE;
                    w_ack_nxt   = w_win_oh;
                    w_gnt_nxt   = w_win;
                    w_block_nxt = req_blk[int'(w_win)*BLK_W +: BLK_W];
`ifdef AES_ARB_PRIO0_EN
                    // Priority grants to requester 0 leave the rotation untouched.
                    if (w_win != '0) w_rr_nxt = w_win;
`else
                    w_rr_nxt    = w_win;
`endif
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (core_ready) begin
                    w_start_nxt = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A flush coinciding with the result discards it; nothing left to drain.
                if (core_done) begin
                    w_state_nxt = S_IDLE;
                    if (!flush) begin
                        w_valid_nxt = w_gnt_oh;
                        w_data_nxt  = core_result;
                        w_id_nxt    = r_gnt;
                    end
                end else if (flush) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (core_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= IDW'(NREQ - 1);
            r_gnt        <= '0;
            r_ack        <= '0;
            r_core_start <= 1'b0;
            r_core_block <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_rsp_id     <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_nxt;
            r_gnt        <= w_gnt_nxt;
            r_ack        <= w_ack_nxt;
            r_core_start <= w_start_nxt;
            r_core_block <= w_block_nxt;
            r_rsp_valid  <= w_valid_nxt;
            r_rsp_data   <= w_data_nxt;
            r_rsp_id     <= w_id_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign ack        = r_ack;
    assign core_start = r_core_start;
    assign core_block = r_core_block;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_rsp_id;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_aes_core_arbiter.sv
// ============================================================================
// Module   : tb_aes_core_arbiter
// Purpose  : Directed self-checking bench for aes_core_arbiter (NREQ=3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes_core_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   req = '0;
    logic [383:0] req_blk;
    logic [2:0]   ack;
    logic [127:0] rsp_data;
    logic [2:0]   rsp_valid;
    logic [1:0]   rsp_id;
    logic         flush = 1'b0;
    logic         core_ready = 1'b0;
    logic         core_start;
    logic [127:0] core_block;
    logic         core_done = 1'b0;
    logic [127:0] core_result = '0;
    logic         busy;

    logic [127:0] blk [3];
    logic [127:0] last_res;
    int           n_checks = 0;
    int           n_errors = 0;
    int           n_txn = 0;

    always #5 clk = ~clk;

    aes_core_arbiter #(.NREQ(3), .BLK_W(128), .IDW(2)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_blk     (req_blk),
        .ack         (ack),
        .rsp_data    (rsp_data),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .flush       (flush),
        .core_ready  (core_ready),
        .core_start  (core_start),
        .core_block  (core_block),
        .core_done   (core_done),
        .core_result (core_result),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_start"}, core_start, 0);
        chk({tag, "_block"}, core_block, 0);
        chk({tag, "_valid"}, rsp_valid, 0);
        chk({tag, "_data"}, rsp_data, 0);
        chk({tag, "_id"}, rsp_id, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("rst");
        tick();
        rst_n = 1'b1;
    endtask

    // Full transaction with core_ready=1: ack, start, dly idle cycles, done, response.
    task automatic t_txn(input logic [2:0] req_v, input logic [2:0] exp_ack, input int dly);
        int id;
        logic [127:0] res;
        id  = (exp_ack == 3'b010) ? 1 : (exp_ack == 3'b100) ? 2 : 0;
        res = {4{32'h5EED0000 + n_txn}};
        n_txn++;
        req = req_v;
        tick();
        chk("ack", ack, exp_ack);
        chk("busy_ack", busy, 1);
        req = req_v & ~exp_ack;
        tick();
        chk("start", core_start, 1);
        chk("block", core_block, blk[id]);
        chk("ack_once", ack, 0);
        for (int i = 0; i < dly; i++) begin
            tick();
            if (i == 0) chk("start_pulse", core_start, 0);
        end
        core_done   = 1'b1;
        core_result = res;
        tick();
        core_done = 1'b0;
        chk("rsp_valid", rsp_valid, exp_ack);
        chk("rsp_id", rsp_id, id);
        chk("rsp_data", rsp_data, res);
        chk("busy_done", busy, 0);
        last_res = res;
    endtask

    initial begin
        blk[0] = 128'h00112233445566778899aabbccddeeff;
        blk[1] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        blk[2] = 128'hcafe_babe_dead_beef_0123_4567_89ab_cdef;
        req_blk = {blk[2], blk[1], blk[0]};

        // Reset state and single request with 14-cycle core latency
        do_reset();
        core_ready = 1'b1;
        t_txn(3'b001, 3'b001, 13);
        tick();
        chk("valid_pulse", rsp_valid, 0);
        chk("data_hold", rsp_data, last_res);

        // All requesters held: round-robin rotation
        do_reset();
`ifdef AES_ARB_PRIO0_EN
        t_txn(3'b111, 3'b001, 2);
        t_txn(3'b111, 3'b001, 2);
        t_txn(3'b111, 3'b001, 2);
        t_txn(3'b111, 3'b001, 2);
`else
        t_txn(3'b111, 3'b001, 2);
        t_txn(3'b111, 3'b010, 2);
        t_txn(3'b111, 3'b100, 2);
        t_txn(3'b111, 3'b001, 2);
`endif
        req = '0;

        // core_ready low for 5 cycles in ISSUE
        core_ready = 1'b0;
        req = 3'b010;
        tick();
        chk("rdy_ack", ack, 3'b010);
        req = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rdy_nostart", core_start, 0);
            chk("rdy_busy", busy, 1);
            chk("rdy_noack", ack, 0);
        end
        core_ready = 1'b1;
        tick();
        chk("rdy_start", core_start, 1);
        chk("rdy_block", core_block, blk[1]);
        core_done = 1'b1;
        core_result = 128'h0;
        tick();
        core_done = 1'b0;
        chk("rdy_valid", rsp_valid, 3'b010);

        // flush in ISSUE: back to IDLE, no start
        core_ready = 1'b0;
        req = 3'b010;
        tick();
        chk("fi_ack", ack, 3'b010);
        req = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        core_ready = 1'b1;
        chk("fi_busy", busy, 0);
        chk("fi_nostart", core_start, 0);
        tick();
        chk("fi_nostart2", core_start, 0);

        // flush three cycles into WAIT: result discarded, pending req served after
        req = 3'b100;
        tick();
        chk("fw_ack", ack, 3'b100);
        req = '0;
        tick();
        chk("fw_start", core_start, 1);
        tick();
        tick();
        flush = 1'b1;
        req = 3'b001;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fw_busy", busy, 1);
            chk("fw_noack", ack, 0);
            chk("fw_novalid", rsp_valid, 0);
        end
        core_done = 1'b1;
        core_result = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
        tick();
        core_done = 1'b0;
        chk("fw_drop", rsp_valid, 0);
        chk("fw_idle", busy, 0);
        t_txn(3'b001, 3'b001, 3);
        req = '0;

        // Reset mid-WAIT, stale core_done after release
        req = 3'b100;
        tick();
        req = '0;
        tick();
        tick();
        chk("mr_busy", busy, 1);
        do_reset();
        tick();
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("mr_stale_valid", rsp_valid, 0);
        chk("mr_stale_busy", busy, 0);
        t_txn(3'b010, 3'b010, 2);
        req = '0;

        // Priority vs rotation: rr_ptr=1, then req 3'b101
        t_txn(3'b000 | 3'b101, 
`ifdef AES_ARB_PRIO0_EN
              3'b001,
`else
              3'b100,
`endif
              2);
`ifdef AES_ARB_PRIO0_EN
        t_txn(3'b100, 3'b100, 2);
`else
        t_txn(3'b001, 3'b001, 2);
`endif

        // req[0] rising alongside pending 3'b110 after reset
        do_reset();
        t_txn(3'b111, 3'b001, 2);
        t_txn(3'b110, 3'b010, 2);
        t_txn(3'b100, 3'b100, 2);
        req = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
